demux1to8_seq: RTL and testbench

DEMUX1TO8_SEQ -- requirements
Module: demux1to8_seq

---
 rtl/demux1to8_seq.sv | 77 +++++++
 tb/tb_demux1to8_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to8_seq.sv
// Sequential 1-to-8 demultiplexer: routes a single data bit into one of eight
// registered lanes, either addressed directly by S or filled in order by a scan frame.
module demux1to8_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       valid,
   input  logic [2:0] S,
   input  logic       mode,
   input  logic       start,
   output logic [7:0] Y,
   output logic [7:0] wr,
   output logic [2:0] ptr,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state;
   logic [2:0] lane;
   logic [7:0] lane_onehot;

   // The lane being written is S in direct mode and the pointer while scanning.
   always_comb begin
      lane        = (state == SCAN) ? ptr : S;
      lane_onehot = 8'h01 << lane;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         Y     <= 8'h00;
         wr    <= 8'h00;
         ptr   <= 3'd0;
      end else begin
         wr <= 8'h00;
         case (state)
            IDLE: begin
               if (!mode) begin
                  if (valid) begin
                     Y[lane] <= din;
                     wr      <= lane_onehot;
                  end
               end else if (start) begin
                  // A new frame clears every lane; a coincident valid is dropped.
                  state <= SCAN;
                  ptr   <= 3'd0;
                  Y     <= 8'h00;
               end
            end
            SCAN: begin
               if (valid) begin
                  Y[lane] <= din;
                  wr      <= lane_onehot;
                  ptr     <= ptr + 3'd1;
                  if (ptr == 3'd7) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == SCAN) || (state == DONE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_demux1to8_seq.sv
// Self-checking bench for demux1to8_seq: directed scenarios followed by random
// traffic, all compared against a lane-array reference model.
module tb_demux1to8_seq;

   logic       clk;
   logic       rst;
   logic       din;
   logic       valid;
   logic [2:0] S;
   logic       mode;
   logic       start;
   logic [7:0] Y;
   logic [7:0] wr;
   logic [2:0] ptr;
   logic       busy;
   logic       done;

   int checks;
   int errors;

   // Reference model: lane contents, frame progress and the last lane written.
   int lanes[8];
   int phase;
   int filled;
   int m_ptr;
   int last_wr;

   demux1to8_seq dut (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .valid (valid),
      .S     (S),
      .mode  (mode),
      .start (start),
      .Y     (Y),
      .wr    (wr),
      .ptr   (ptr),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] modelY();
      int acc;
      acc = 0;
      for (int i = 0; i < 8; i++) acc += lanes[i] * (1 << i);
      return acc[7:0];
   endfunction

   function automatic logic [7:0] modelWr();
      int v;
      v = (last_wr < 0) ? 0 : (1 << last_wr);
      return v[7:0];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 8; i++) lanes[i] = 0;
      phase   = 0;
      filled  = 0;
      m_ptr   = 0;
      last_wr = -1;
   endtask

   // Phase 0 = idle, 1 = frame in progress, 2 = frame complete.
   task automatic modelEdge();
      last_wr = -1;
      if (phase == 0) begin
         if (mode == 1'b0 && valid) begin
            lanes[S] = din;
            last_wr  = S;
         end else if (mode == 1'b1 && start) begin
            for (int i = 0; i < 8; i++) lanes[i] = 0;
            filled = 0;
            m_ptr  = 0;
            phase  = 1;
         end
      end else if (phase == 1) begin
         if (valid) begin
            lanes[filled] = din;
            last_wr       = filled;
            filled        = filled + 1;
            m_ptr         = filled % 8;
            if (filled == 8) phase = 2;
         end
      end else begin
         phase = 0;
      end
   endtask

   task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [7:0] m_ptr8;
      m_ptr8 = m_ptr[7:0];
      checkVal({tag, "_Y"}, Y, modelY());
      checkVal({tag, "_wr"}, wr, modelWr());
      checkVal({tag, "_ptr"}, {5'd0, ptr}, m_ptr8);
      checkVal({tag, "_busy"}, {7'd0, busy}, (phase != 0) ? 8'd1 : 8'd0);
      checkVal({tag, "_done"}, {7'd0, done}, (phase == 2) ? 8'd1 : 8'd0);
      checkVal({tag, "_wr_onehot"}, ($countones(wr) <= 1) ? 8'd1 : 8'd0, 8'd1);
   endtask

   task automatic applyStimulus(input string tag, input logic d, input logic v,
                                input logic [2:0] s, input logic m, input logic st);
      @(negedge clk);
      din   = d;
      valid = v;
      S     = s;
      mode  = m;
      start = st;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [7:0] pattern;
      logic [7:0] ones;
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      din     = 1'b0;
      valid   = 1'b0;
      S       = 3'd0;
      mode    = 1'b0;
      start   = 1'b0;
      modelReset();
      #2;
      checkOutput("reset");
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] direct writes");
      applyStimulus("direct_s5", 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
      checkVal("direct_s5_Yconst", Y, 8'h20);
      checkVal("direct_s5_wrconst", wr, 8'h20);
      applyStimulus("direct_s2", 1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
      checkVal("direct_s2_Yconst", Y, 8'h24);
      checkVal("direct_s2_wrconst", wr, 8'h04);
      applyStimulus("direct_idle", 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
      applyStimulus("scanmode_novalid", 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);

      $display("[TB] full scan");
      applyStimulus("full_start", 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
      pattern = 8'b0100_1101;
      for (int i = 0; i < 8; i++) begin
         applyStimulus("full_lane", pattern[i], 1'b1, 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'b0);
      end
      checkVal("full_Yconst", Y, 8'h4D);
      checkVal("full_doneconst", {7'd0, done}, 8'd1);
      checkVal("full_ptrconst", {5'd0, ptr}, 8'd0);
      applyStimulus("done_valid", 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
      checkVal("after_done_Yconst", Y, 8'h4D);
      checkVal("after_done_busyconst", {7'd0, busy}, 8'd0);

      $display("[TB] gapped scan");
      applyStimulus("gap_start", 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus("gap_lane_lo", pattern[i], 1'b1, 3'd7, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("gap_hold", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
         checkVal("gap_ptrconst", {5'd0, ptr}, 8'd4);
         checkVal("gap_wrconst", wr, 8'h00);
      end
      for (int i = 4; i < 8; i++) applyStimulus("gap_lane_hi", pattern[i], 1'b1, 3'd0, 1'b1, 1'b0);
      checkVal("gap_Yconst", Y, 8'h4D);
      applyStimulus("gap_done_exit", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

      $display("[TB] start/valid precedence");
      ones = 8'hFF;
      for (int i = 0; i < 8; i++) applyStimulus("fill_ones", ones[i], 1'b1, 3'(i), 1'b0, 1'b0);
      checkVal("fill_Yconst", Y, 8'hFF);
      applyStimulus("prec_start", 1'b1, 1'b1, 3'd3, 1'b1, 1'b1);
      checkVal("prec_Yconst", Y, 8'h00);
      checkVal("prec_wrconst", wr, 8'h00);
      checkVal("prec_busyconst", {7'd0, busy}, 8'd1);
      for (int i = 0; i < 3; i++) applyStimulus("prec_lane", 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
      applyStimulus("prec_restart", 1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
      checkVal("prec_ptr4const", {5'd0, ptr}, 8'd4);

      $display("[TB] async reset mid-frame");
      applyStimulus("ar_lane4", 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
      checkVal("ar_ptr5const", {5'd0, ptr}, 8'd5);
      @(negedge clk);
      valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput("ar_async");
      checkVal("ar_Yconst", Y, 8'h00);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus("ar_after", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
